// File: rtl/data_mem_responder.sv
// Data-memory responder: one load/store at a time over valid/ready, executed on an
// internal word array, answered after a fixed LATENCY with extended read data.
module data_mem_responder #(
   parameter int ADDR_W  = 10,
   parameter int LATENCY = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        reqValid,
   output logic        reqReady,
   input  logic        reqWrite,
   input  logic [2:0]  reqSize,
   input  logic [31:0] reqAddr,
   input  logic [31:0] reqWData,
   output logic        respValid,
   input  logic        respReady,
   output logic [31:0] respRData,
   output logic        respErr
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic [3:0] LAT_INIT = 4'(LATENCY - 1);

   state_t      state;
   state_t      next_state;
   logic [3:0]  count;
   logic [3:0]  next_count;

   logic        lat_write;
   logic [2:0]  lat_size;
   logic [31:0] lat_addr;
   logic [31:0] lat_wdata;

   logic        accept;
   logic        enter_resp;
   logic        op_write;
   logic [2:0]  op_size;
   logic [31:0] op_addr;
   logic [31:0] op_wdata;
   logic [ADDR_W-1:0] word_idx;
   logic [1:0]  lane;
   logic [31:0] cur_word;
   logic        access_err;
   logic [31:0] load_data;
   logic [31:0] wr_mask;
   logic [31:0] wr_data;
   logic        do_write;
   logic        next_valid;
   logic [31:0] next_rdata;
   logic        next_err;
   logic        unused_addr_bits;

   logic [31:0] mem [0:(1<<ADDR_W)-1];

   function automatic logic size_illegal(input logic write, input logic [2:0] size);
      case (size)
         3'b000, 3'b001, 3'b010: size_illegal = 1'b0;
         3'b100, 3'b101:         size_illegal = write;
         default:                size_illegal = 1'b1;
      endcase
   endfunction

   function automatic logic misaligned(input logic [2:0] size, input logic [1:0] ln);
      case (size[1:0])
         2'b01:   misaligned = ln[0];
         2'b10:   misaligned = (ln != 2'b00);
         default: misaligned = 1'b0;
      endcase
   endfunction

   function automatic logic [31:0] extend_load(input logic [2:0] size, input logic [1:0] ln,
                                               input logic [31:0] word);
      logic [7:0]  b;
      logic [15:0] h;
      b = 8'(word >> {ln, 3'b000});
      h = ln[1] ? word[31:16] : word[15:0];
      case (size)
         3'b000:  extend_load = {{24{b[7]}}, b};
         3'b001:  extend_load = {{16{h[15]}}, h};
         3'b010:  extend_load = word;
         3'b100:  extend_load = {24'd0, b};
         3'b101:  extend_load = {16'd0, h};
         default: extend_load = 32'd0;
      endcase
   endfunction

   function automatic logic [31:0] store_mask(input logic [2:0] size, input logic [1:0] ln);
      case (size)
         3'b000:  store_mask = 32'h0000_00FF << {ln, 3'b000};
         3'b001:  store_mask = ln[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
         3'b010:  store_mask = 32'hFFFF_FFFF;
         default: store_mask = 32'h0000_0000;
      endcase
   endfunction

   function automatic logic [31:0] store_replicate(input logic [2:0] size, input logic [31:0] d);
      case (size)
         3'b000:  store_replicate = {4{d[7:0]}};
         3'b001:  store_replicate = {2{d[15:0]}};
         default: store_replicate = d;
      endcase
   endfunction

   assign reqReady         = (state == IDLE);
   assign accept           = reqValid & reqReady;
   assign unused_addr_bits = ^reqAddr[31:ADDR_W+2] ^ (^lat_addr[31:ADDR_W+2]);

   // With LATENCY==1 the access happens on the acceptance edge, so use the live inputs.
   assign op_write   = (state == IDLE) ? reqWrite : lat_write;
   assign op_size    = (state == IDLE) ? reqSize  : lat_size;
   assign op_addr    = (state == IDLE) ? reqAddr  : lat_addr;
   assign op_wdata   = (state == IDLE) ? reqWData : lat_wdata;
   assign word_idx   = op_addr[ADDR_W+1:2];
   assign lane       = op_addr[1:0];
   assign cur_word   = mem[word_idx];
   assign access_err = size_illegal(op_write, op_size) | misaligned(op_size, lane);
   assign load_data  = extend_load(op_size, lane, cur_word);
   assign wr_mask    = store_mask(op_size, lane);
   assign wr_data    = store_replicate(op_size, op_wdata);
   assign enter_resp = (next_state == RESP) && (state != RESP);

   // State and latency counter register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         count <= 4'd0;
      end else begin
         state <= next_state;
         count <= next_count;
      end
   end

   // Next-state logic.
   always_comb begin
      next_state = state;
      next_count = count;
      case (state)
         IDLE: begin
            if (accept) begin
               next_count = LAT_INIT;
               if (LATENCY == 1) begin
                  next_state = RESP;
               end else begin
                  next_state = WAIT;
               end
            end else begin
               next_state = IDLE;
            end
         end
         WAIT: begin
            if (count <= 4'd1) begin
               next_state = RESP;
               next_count = 4'd0;
            end else begin
               next_count = count - 4'd1;
            end
         end
         RESP: begin
            if (respReady) begin
               next_state = IDLE;
            end else begin
               next_state = RESP;
            end
         end
         default: begin
            next_state = IDLE;
            next_count = 4'd0;
         end
      endcase
   end

   // Output logic: the access result is captured on the edge that enters RESP.
   always_comb begin
      next_valid = respValid;
      next_rdata = respRData;
      next_err   = respErr;
      do_write   = 1'b0;
      if (enter_resp) begin
         next_valid = 1'b1;
         next_err   = access_err;
         next_rdata = (access_err | op_write) ? 32'd0 : load_data;
         do_write   = op_write & ~access_err;
      end else if (next_state != RESP) begin
         next_valid = 1'b0;
         next_rdata = 32'd0;
         next_err   = 1'b0;
      end else begin
         next_valid = respValid;
      end
   end

   // Registered response outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         respValid <= 1'b0;
         respRData <= 32'd0;
         respErr   <= 1'b0;
      end else begin
         respValid <= next_valid;
         respRData <= next_rdata;
         respErr   <= next_err;
      end
   end

   // Request capture at acceptance.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lat_write <= 1'b0;
         lat_size  <= 3'd0;
         lat_addr  <= 32'd0;
         lat_wdata <= 32'd0;
      end else if (accept) begin
         lat_write <= reqWrite;
         lat_size  <= reqSize;
         lat_addr  <= reqAddr;
         lat_wdata <= reqWData;
      end else begin
         lat_write <= lat_write;
      end
   end

   // Word array, deliberately not reset.
   always_ff @(posedge clk) begin
      if (do_write) begin
         mem[word_idx] <= (cur_word & ~wr_mask) | (wr_data & wr_mask);
      end
   end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: two instances (LATENCY 2 and 1) share one request stream
// and are checked against a byte-addressed reference model and a directed vector table.
module tb_data_mem_responder;

   localparam int MEM_BYTES = 4 << 10;

   logic        clk = 1'b0;
   logic        rst;
   logic        reqValid, reqWrite, respReady;
   logic [2:0]  reqSize;
   logic [31:0] reqAddr, reqWData;
   logic        ready_a, valid_a, err_a, ready_b, valid_b, err_b;
   logic [31:0] rdata_a, rdata_b;

   int errors = 0;
   int checks = 0;

   bit [7:0] ref_bytes [int];

   typedef struct {
      logic        w;
      logic [2:0]  s;
      logic [31:0] a;
      logic [31:0] d;
      int          stall;
      logic [31:0] er;
      logic        ee;
   } vec_t;

   vec_t vecs [20];

   always #5 clk = ~clk;

   data_mem_responder #(.ADDR_W(10), .LATENCY(2)) dut_a (
      .clk(clk), .rst(rst), .reqValid(reqValid), .reqReady(ready_a), .reqWrite(reqWrite),
      .reqSize(reqSize), .reqAddr(reqAddr), .reqWData(reqWData), .respValid(valid_a),
      .respReady(respReady), .respRData(rdata_a), .respErr(err_a));

   data_mem_responder #(.ADDR_W(10), .LATENCY(1)) dut_b (
      .clk(clk), .rst(rst), .reqValid(reqValid), .reqReady(ready_b), .reqWrite(reqWrite),
      .reqSize(reqSize), .reqAddr(reqAddr), .reqWData(reqWData), .respValid(valid_b),
      .respReady(respReady), .respRData(rdata_b), .respErr(err_b));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference: memory as bytes, accesses as little-endian byte groups.
   task automatic model(input logic w, input logic [2:0] size, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic [31:0] rd, output logic er);
      int          n;
      int          base;
      logic        legal;
      logic [31:0] v;
      base  = int'(addr % MEM_BYTES);
      legal = w ? (size <= 3'd2) : (size <= 3'd2 || size == 3'd4 || size == 3'd5);
      rd = 32'd0;
      er = 1'b0;
      if (!legal) begin
         er = 1'b1;
         return;
      end
      n = 1 << size[1:0];
      if ((base % n) != 0) begin
         er = 1'b1;
         return;
      end
      if (w) begin
         for (int i = 0; i < n; i++) ref_bytes[base + i] = wdata[8*i +: 8];
      end else begin
         v = 32'd0;
         for (int i = 0; i < n; i++) v = v | (32'(ref_bytes[base + i]) << (8 * i));
         if (!size[2] && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
         rd = v;
      end
   endtask

   task automatic do_txn(input logic w, input logic [2:0] s, input logic [31:0] a,
                         input logic [31:0] d, input int stall,
                         output logic [31:0] ra, output logic ea,
                         output logic [31:0] rb, output logic eb);
      int lat_a;
      int lat_b;
      lat_a = 0;
      lat_b = 0;
      @(negedge clk);
      chk("ready_before", {30'd0, ready_a, ready_b}, 32'd3);
      reqValid = 1'b1; reqWrite = w; reqSize = s; reqAddr = a; reqWData = d; respReady = 1'b0;
      @(posedge clk); #1;
      reqValid = 1'b0;
      reqWrite = ~w;
      reqSize  = 3'($urandom);
      reqAddr  = $urandom;
      reqWData = $urandom;
      for (int e = 1; e <= 20; e++) begin
         if (e > 1) begin
            @(posedge clk); #1;
         end
         if (valid_a && lat_a == 0) lat_a = e;
         if (valid_b && lat_b == 0) lat_b = e;
         if (lat_a != 0 && lat_b != 0) break;
      end
      chk("latency_a", lat_a, 32'd2);
      chk("latency_b", lat_b, 32'd1);
      @(negedge clk);
      ra = rdata_a; ea = err_a; rb = rdata_b; eb = err_b;
      for (int i = 0; i < stall; i++) begin
         reqValid = 1'b1; reqWrite = 1'b1; reqSize = 3'b010; reqAddr = a; reqWData = 32'd0;
         @(posedge clk); #1;
         chk("stall_valid", {30'd0, valid_a, valid_b}, 32'd3);
         chk("stall_ready", {30'd0, ready_a, ready_b}, 32'd0);
         chk("stall_data_a", rdata_a, ra);
         chk("stall_data_b", rdata_b, rb);
      end
      reqValid  = 1'b0;
      respReady = 1'b1;
      @(posedge clk); #1;
      respReady = 1'b0;
      chk("hs_valid", {30'd0, valid_a, valid_b}, 32'd0);
      chk("hs_ready", {30'd0, ready_a, ready_b}, 32'd3);
      chk("idle_out", rdata_a | rdata_b | {31'd0, err_a | err_b}, 32'd0);
   endtask

   initial begin
      logic [31:0] ra, rb, mr;
      logic        ea, eb, me;
      logic        w;
      logic [2:0]  s;
      logic [31:0] a, d;

      rst = 1'b1; reqValid = 1'b0; respReady = 1'b0; reqWrite = 1'b0;
      reqSize = 3'd0; reqAddr = 32'd0; reqWData = 32'd0;

      vecs[0]  = '{1'b1, 3'b010, 32'h10,   32'hDEADBEEF, 0, 32'h0,        1'b0};
      vecs[1]  = '{1'b0, 3'b010, 32'h10,   32'h0,        0, 32'hDEADBEEF, 1'b0};
      vecs[2]  = '{1'b0, 3'b000, 32'h13,   32'h0,        0, 32'hFFFFFFDE, 1'b0};
      vecs[3]  = '{1'b0, 3'b100, 32'h13,   32'h0,        0, 32'h000000DE, 1'b0};
      vecs[4]  = '{1'b0, 3'b001, 32'h12,   32'h0,        0, 32'hFFFFDEAD, 1'b0};
      vecs[5]  = '{1'b0, 3'b101, 32'h10,   32'h0,        0, 32'h0000BEEF, 1'b0};
      vecs[6]  = '{1'b1, 3'b000, 32'h11,   32'h12345677, 0, 32'h0,        1'b0};
      vecs[7]  = '{1'b0, 3'b010, 32'h10,   32'h0,        0, 32'hDEAD77EF, 1'b0};
      vecs[8]  = '{1'b1, 3'b001, 32'h12,   32'h0000ABCD, 0, 32'h0,        1'b0};
      vecs[9]  = '{1'b0, 3'b010, 32'h10,   32'h0,        0, 32'hABCD77EF, 1'b0};
      vecs[10] = '{1'b0, 3'b010, 32'h12,   32'h0,        0, 32'h0,        1'b1};
      vecs[11] = '{1'b1, 3'b001, 32'h13,   32'h0000FFFF, 0, 32'h0,        1'b1};
      vecs[12] = '{1'b0, 3'b011, 32'h10,   32'h0,        0, 32'h0,        1'b1};
      vecs[13] = '{1'b1, 3'b100, 32'h10,   32'h000000AA, 0, 32'h0,        1'b1};
      vecs[14] = '{1'b0, 3'b010, 32'h10,   32'h0,        5, 32'hABCD77EF, 1'b0};
      vecs[15] = '{1'b0, 3'b010, 32'h10,   32'h0,        0, 32'hABCD77EF, 1'b0};
      vecs[16] = '{1'b1, 3'b010, 32'h20,   32'h00000011, 0, 32'h0,        1'b0};
      vecs[17] = '{1'b0, 3'b010, 32'h20,   32'h0,        0, 32'h00000011, 1'b0};
      vecs[18] = '{1'b0, 3'b010, 32'h1010, 32'h0,        0, 32'hABCD77EF, 1'b0};
      vecs[19] = '{1'b0, 3'b001, 32'h11,   32'h0,        0, 32'h0,        1'b1};

      #12;
      chk("rst_valid", {30'd0, valid_a, valid_b}, 32'd0);
      chk("rst_ready", {30'd0, ready_a, ready_b}, 32'd3);
      chk("rst_out", rdata_a | rdata_b | {31'd0, err_a | err_b}, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 20; i++) begin
         do_txn(vecs[i].w, vecs[i].s, vecs[i].a, vecs[i].d, vecs[i].stall, ra, ea, rb, eb);
         model(vecs[i].w, vecs[i].s, vecs[i].a, vecs[i].d, mr, me);
         chk($sformatf("vec%0d_rdata_a", i), ra, vecs[i].er);
         chk($sformatf("vec%0d_err_a", i), {31'd0, ea}, {31'd0, vecs[i].ee});
         chk($sformatf("vec%0d_rdata_b", i), rb, vecs[i].er);
         chk($sformatf("vec%0d_err_b", i), {31'd0, eb}, {31'd0, vecs[i].ee});
      end

      // Reset while the LATENCY=2 instance waits; the LATENCY=1 instance has already committed.
      @(negedge clk);
      reqValid = 1'b1; reqWrite = 1'b1; reqSize = 3'b010; reqAddr = 32'h20; reqWData = 32'h55;
      @(posedge clk); #1;
      reqValid = 1'b0;
      chk("wait_valid_a", {31'd0, valid_a}, 32'd0);
      chk("resp_valid_b", {31'd0, valid_b}, 32'd1);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("midrst_valid", {30'd0, valid_a, valid_b}, 32'd0);
      chk("midrst_ready", {30'd0, ready_a, ready_b}, 32'd3);
      @(negedge clk);
      rst = 1'b0;
      do_txn(1'b0, 3'b010, 32'h20, 32'h0, 0, ra, ea, rb, eb);
      chk("dropped_store_a", ra, 32'h11);
      chk("committed_store_b", rb, 32'h55);
      do_txn(1'b1, 3'b010, 32'h20, 32'h11, 0, ra, ea, rb, eb);

      for (int i = 0; i < 8; i++) begin
         d = $urandom;
         a = 32'h100 + 32'(4 * i);
         do_txn(1'b1, 3'b010, a, d, 0, ra, ea, rb, eb);
         model(1'b1, 3'b010, a, d, mr, me);
      end
      for (int i = 0; i < 150; i++) begin
         w = 1'($urandom % 2);
         s = 3'($urandom % 8);
         a = 32'h100 + 32'($urandom % 32) + 32'(($urandom % 4) * MEM_BYTES);
         d = $urandom;
         do_txn(w, s, a, d, 0, ra, ea, rb, eb);
         model(w, s, a, d, mr, me);
         chk("rand_rdata_a", ra, mr);
         chk("rand_err_a", {31'd0, ea}, {31'd0, me});
         chk("rand_rdata_b", rb, mr);
         chk("rand_err_b", {31'd0, eb}, {31'd0, me});
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
